// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 16x-oversampled UART receiver.
// Frame format (7/8 data bits, none/odd/even parity, 1/2 stop bits) is
// latched at start-bit detection so mid-frame config changes are ignored.
// Optional build macro UART_RX_MAJORITY_EN: each bit becomes the 2-of-3
// majority of the last three ticks up to the sample point instead of a
// single mid-bit sample.
module uart_rx_fsm #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bd_tick,
  input  logic       rx,
  input  logic       D_num,
  input  logic       S_num,
  input  logic [1:0] Par,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       is_active
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] HALF_LAST = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            cfg_dnum, cfg_dnum_n;
  logic            cfg_snum, cfg_snum_n;
  logic [1:0]      cfg_par, cfg_par_n;
  logic            par_flag, par_flag_n;
  logic            frm_flag, frm_flag_n;
  logic [7:0]      data_n;
  logic            done_n;
  logic            perr_n;
  logic            ferr_n;
  logic            active_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic                   bit_val;
  logic [7:0]             word;
  logic                   par_en;
  logic                   par_exp;
  logic [2:0]             last_data;
  logic [2:0]             last_stop;

  // rx metastability synchronizer; idles high so reset looks like an idle line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [TW-1:0] samp_pt;
  logic [1:0]    maj_hist;

  assign samp_pt = (state == START) ? HALF_LAST : FULL_LAST;

  // capture the two ticks just before the sample point for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maj_hist <= 2'b11;
    end else if (bd_tick && ((tick_cnt == samp_pt - TW'(2)) ||
                             (tick_cnt == samp_pt - TW'(1)))) begin
      maj_hist <= {maj_hist[0], rxs};
    end
  end

  assign bit_val = (maj_hist[1] & maj_hist[0]) |
                   (maj_hist[1] & rxs) |
                   (maj_hist[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  // 7-bit words were shifted in one position short, so they sit in [7:1]
  assign word      = cfg_dnum ? shreg : {1'b0, shreg[7:1]};
  assign par_en    = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  assign par_exp   = (cfg_par == 2'b01) ? ~(^word) : (^word);
  assign last_data = cfg_dnum ? 3'd7 : 3'd6;
  assign last_stop = cfg_snum ? 3'd1 : 3'd0;

  // state, counters, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cfg_dnum   <= 1'b0;
      cfg_snum   <= 1'b0;
      cfg_par    <= 2'b00;
      par_flag   <= 1'b0;
      frm_flag   <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      is_active  <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      cfg_dnum   <= cfg_dnum_n;
      cfg_snum   <= cfg_snum_n;
      cfg_par    <= cfg_par_n;
      par_flag   <= par_flag_n;
      frm_flag   <= frm_flag_n;
      rx_data    <= data_n;
      rx_done    <= done_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      is_active  <= active_n;
    end
  end

  // next-state and next-output logic; everything moves only on bd_tick
  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    cfg_dnum_n = cfg_dnum;
    cfg_snum_n = cfg_snum;
    cfg_par_n  = cfg_par;
    par_flag_n = par_flag;
    frm_flag_n = frm_flag;
    data_n     = rx_data;
    done_n     = 1'b0;
    perr_n     = parity_err;
    ferr_n     = frame_err;
    active_n   = is_active;

    if (bd_tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n    = START;
            tick_n     = '0;
            cfg_dnum_n = D_num;
            cfg_snum_n = S_num;
            cfg_par_n  = Par;
            par_flag_n = 1'b0;
            frm_flag_n = 1'b0;
            active_n   = 1'b1;
          end
        end

        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_n = '0;
            bit_n  = '0;
            if (!bit_val) begin
              state_n = DATA;
            end else begin
              state_n  = IDLE;
              active_n = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end

        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_n  = '0;
            shreg_n = {bit_val, shreg[7:1]};
            if (bit_cnt == last_data) begin
              bit_n   = '0;
              state_n = par_en ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end

        PARITY: begin
          if (tick_cnt == FULL_LAST) begin
            tick_n     = '0;
            bit_n      = '0;
            par_flag_n = (bit_val != par_exp);
            state_n    = STOP;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end

        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_n     = '0;
            frm_flag_n = frm_flag | ~bit_val;
            if (bit_cnt == last_stop) begin
              bit_n    = '0;
              data_n   = word;
              perr_n   = par_flag;
              ferr_n   = frm_flag | ~bit_val;
              done_n   = 1'b1;
              active_n = 1'b0;
              // a line still low after a bad stop must not look like a new start
              state_n  = (frm_flag | ~bit_val) ? WAIT_HIGH : IDLE;
            end else begin
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end

        WAIT_HIGH: begin
          active_n = 1'b0;
          if (rxs) state_n = IDLE;
        end

        default: begin
          state_n  = IDLE;
          tick_n   = '0;
          bit_n    = '0;
          active_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed frames plus randomized frames checked
// against a frame-level model (masked word, parity rule, stop-bit rule,
// active duration in ticks).
module tb_uart_rx_fsm;

  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bd_tick = 1'b0;
  logic       rx = 1'b1;
  logic       D_num = 1'b1;
  logic       S_num = 1'b0;
  logic [1:0] Par = 2'b00;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       is_active;

  int errors = 0;
  int checks = 0;

  int       done_cnt = 0;
  int       done_long = 0;
  int       act_ticks = 0;
  logic     prev_done = 1'b0;
  logic [7:0] cap_data = '0;
  logic     cap_perr = 1'b0;
  logic     cap_ferr = 1'b0;
  int       div = 0;

  uart_rx_fsm #(.OSR(OSR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx),
    .D_num(D_num), .S_num(S_num), .Par(Par),
    .rx_data(rx_data), .rx_done(rx_done), .parity_err(parity_err),
    .frame_err(frame_err), .is_active(is_active)
  );

  always #5 clk = ~clk;

  // baud tick every third clk, changed on the falling edge
  always @(negedge clk) begin
    div = (div == 2) ? 0 : div + 1;
    bd_tick = (div == 0);
  end

  // observe done pulses and active duration just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rx_done) begin
      done_cnt++;
      cap_data = rx_data;
      cap_perr = parity_err;
      cap_ferr = frame_err;
      if (prev_done) done_long++;
    end
    prev_done = rx_done;
    if (bd_tick && is_active) act_ticks++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!bd_tick);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(OSR);
  endtask

  task automatic send_frame(input string tag, input logic dn, input logic sn,
                            input logic [1:0] pr, input logic [7:0] d,
                            input logic bad_par, input logic [1:0] stop_val,
                            input int extra_low);
    int         nd, nbits, d0, a0;
    logic       pen, pbit, ef, ep;
    logic [7:0] ed;
    pen   = (pr == 2'b01) || (pr == 2'b10);
    nd    = dn ? 8 : 7;
    ed    = dn ? d : {1'b0, d[6:0]};
    pbit  = (pr == 2'b01) ? ~(^ed) : (^ed);
    if (bad_par) pbit = ~pbit;
    ep    = pen && bad_par;
    ef    = !stop_val[0] || (sn && !stop_val[1]);
    nbits = nd + (pen ? 1 : 0) + (sn ? 2 : 1);
    D_num = dn; S_num = sn; Par = pr;
    d0 = done_cnt; a0 = act_ticks;
    send_bit(1'b0);
    D_num = 1'($urandom); S_num = 1'($urandom); Par = 2'($urandom);
    for (int i = 0; i < nd; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop_val[0]);
    if (sn) send_bit(stop_val[1]);
    if (extra_low > 0) begin
      rx = 1'b0;
      wait_ticks(extra_low);
      chk({tag, ":held_low_done"}, done_cnt - d0, 1);
      chk({tag, ":held_low_active"}, is_active, 0);
    end
    rx = 1'b1;
    wait_ticks(6);
    chk({tag, ":done_count"}, done_cnt - d0, 1);
    chk({tag, ":data"}, cap_data, ed);
    chk({tag, ":parity_err"}, cap_perr, ep);
    chk({tag, ":frame_err"}, cap_ferr, ef);
    chk({tag, ":active_ticks"}, act_ticks - a0, 8 + OSR * nbits);
    chk({tag, ":data_held"}, rx_data, ed);
    chk({tag, ":done_width"}, done_long, 0);
  endtask

  initial begin
    int d0, a0;
    // reset state
    repeat (5) @(posedge clk);
    #1;
    chk("reset:rx_data", rx_data, 0);
    chk("reset:rx_done", rx_done, 0);
    chk("reset:parity_err", parity_err, 0);
    chk("reset:frame_err", frame_err, 0);
    chk("reset:is_active", is_active, 0);
    rst = 1'b1;
    wait_ticks(4);

    send_frame("8N1_A5", 1'b1, 1'b0, 2'b00, 8'hA5, 1'b0, 2'b11, 0);
    send_frame("7E2_35", 1'b0, 1'b1, 2'b10, 8'h35, 1'b0, 2'b11, 0);
    send_frame("8O1_0F_badpar", 1'b1, 1'b0, 2'b01, 8'h0F, 1'b1, 2'b11, 0);
    send_frame("8N1_3C_badstop", 1'b1, 1'b0, 2'b00, 8'h3C, 1'b0, 2'b00, 2 * OSR);
    send_frame("8N1_81", 1'b1, 1'b0, 2'b00, 8'h81, 1'b0, 2'b11, 0);

    // glitch: short low pulse must be rejected as a false start
    d0 = done_cnt; a0 = act_ticks;
    rx = 1'b0;
    wait_ticks(4);
    chk("glitch:active_during", is_active, 1);
    rx = 1'b1;
    wait_ticks(12);
    chk("glitch:active_after", is_active, 0);
    chk("glitch:no_done", done_cnt - d0, 0);
    chk("glitch:active_ticks", act_ticks - a0, 8);

    // reset during data bit 4 of 0xFF
    d0 = done_cnt;
    D_num = 1'b1; S_num = 1'b0; Par = 2'b00;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_ticks(OSR / 2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst:rx_data", rx_data, 0);
    chk("midrst:rx_done", rx_done, 0);
    chk("midrst:parity_err", parity_err, 0);
    chk("midrst:frame_err", frame_err, 0);
    chk("midrst:is_active", is_active, 0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ticks(4);
    chk("midrst:no_done", done_cnt - d0, 0);
    send_frame("after_rst_12", 1'b1, 1'b0, 2'b00, 8'h12, 1'b0, 2'b11, 0);

    // randomized frames; consecutive frames also exercise back-to-back starts
    for (int n = 0; n < 16; n++) begin
      logic       dn, sn, bp;
      logic [1:0] pr, sv;
      logic [7:0] d;
      dn = 1'($urandom);
      sn = 1'($urandom);
      pr = 2'($urandom);
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
      send_frame($sformatf("rand%0d", n), dn, sn, pr, d, bp, sv, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
